// File: rtl/enc_speed_meter_if.sv
// Encoder speed meter port bundle: enable and raw tick pins in, scaled speed and status out.
// The master side drives the pins; the meter itself sits on the slave side.
interface enc_speed_meter_if #(
    parameter int RPM_W = 10
);
    logic             en;
    logic             tick_a;
    logic             tick_b;
    logic [RPM_W-1:0] rpm;
    logic             dir;
    logic             rpm_valid;
    logic             cnt_ovf;
    logic             rpm_sat;
    logic             quad_err;
    logic             stall;

    modport master (
        output en, tick_a, tick_b,
        input  rpm, dir, rpm_valid, cnt_ovf, rpm_sat, quad_err, stall
    );

    modport slave (
        input  en, tick_a, tick_b,
        output rpm, dir, rpm_valid, cnt_ovf, rpm_sat, quad_err, stall
    );
endinterface

// File: rtl/enc_speed_meter.sv
// Gated-window encoder speed meter: counts rising edges or x4 quadrature steps per window, scales to RPM by multiply/shift.
// Pin-to-count 3 clk; rpm_valid one clk after the window-closing edge; no backpressure, exactly one strobe per window.
module enc_speed_meter #(
    parameter int MODE          = 0,
    parameter int GATE_CYCLES   = 160000,
    parameter int CNT_W         = 16,
    parameter int RPM_NUM       = 60,
    parameter int RPM_SHIFT     = 8,
    parameter int RPM_W         = 10,
    parameter int STALL_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    enc_speed_meter_if.slave bus
);
    localparam int GATE_W  = $clog2(GATE_CYCLES);
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
    localparam int PROD_W  = CNT_W + 16;

    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0]  GATE_ONE  = GATE_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   U_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   S_MAX     = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]   S_MIN     = ~S_MAX + CNT_ONE;
    localparam logic [15:0]        NUM       = 16'(RPM_NUM);

    // Synchroniser chain, bit 1 = channel A, bit 0 = channel B
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] hist_q, hist_d;

    logic rise_a;
    logic step_up;
    logic step_dn;
    logic step_err;

    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_win;
    logic              ovf_q, ovf_d, ovf_win;
    logic              err_q, err_d, err_win;
    logic              win_last;

    logic [CNT_W-1:0]  snap_q, snap_d;
    logic              snap_vld_q, snap_vld_d;
    logic              snap_ovf_q, snap_ovf_d;
    logic              snap_err_q, snap_err_d;

    logic              fire;
    logic [CNT_W-1:0]  mag;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] res;

    logic [RPM_W-1:0]   rpm_q, rpm_d;
    logic               dir_q, dir_d;
    logic               valid_q, valid_d;
    logic               cnt_ovf_q, cnt_ovf_d;
    logic               rpm_sat_q, rpm_sat_d;
    logic               quad_err_q, quad_err_d;
    logic               stall_q, stall_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // History tracks regardless of en, so a level held across enable is never seen as an edge
    always_comb begin
        meta_d = {bus.tick_a, bus.tick_b};
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_comb begin
        rise_a   = sync_q[1] & ~hist_q[1];
        step_up  = 1'b0;
        step_dn  = 1'b0;
        step_err = 1'b0;
        case ({hist_q, sync_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up  = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn  = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: step_err = 1'b1;
            default: ;
        endcase
    end

    // Count and flags as they stand including this cycle's edge
    always_comb begin
        cnt_win = cnt_q;
        ovf_win = ovf_q;
        err_win = err_q;
        if (MODE == 0) begin
            if (rise_a) begin
                if (cnt_q == U_MAX) ovf_win = 1'b1;
                else                cnt_win = cnt_q + CNT_ONE;
            end
        end else begin
            if (step_err) err_win = 1'b1;
            if (step_up) begin
                if (cnt_q == S_MAX) ovf_win = 1'b1;
                else                cnt_win = cnt_q + CNT_ONE;
            end else if (step_dn) begin
                if (cnt_q == S_MIN) ovf_win = 1'b1;
                else                cnt_win = cnt_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        win_last   = (gate_q == GATE_LAST);
        gate_d     = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
        err_d      = 1'b0;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        snap_err_d = snap_err_q;
        snap_vld_d = 1'b0;
        if (!bus.en) begin
            snap_d     = '0;
            snap_ovf_d = 1'b0;
            snap_err_d = 1'b0;
        end else if (win_last) begin
            snap_d     = cnt_win;
            snap_ovf_d = ovf_win;
            snap_err_d = err_win;
            snap_vld_d = 1'b1;
        end else begin
            gate_d = gate_q + GATE_ONE;
            cnt_d  = cnt_win;
            ovf_d  = ovf_win;
            err_d  = err_win;
        end
    end

    // Magnitude is safe to negate: the signed count never reaches the most negative code
    always_comb begin
        fire = snap_vld_q & bus.en;
        mag  = (MODE != 0 && snap_q[CNT_W-1]) ? (~snap_q + CNT_ONE) : snap_q;
        prod = PROD_W'(mag) * PROD_W'(NUM);
        res  = prod >> RPM_SHIFT;
    end

    always_comb begin
        rpm_d       = rpm_q;
        dir_d       = dir_q;
        valid_d     = 1'b0;
        cnt_ovf_d   = cnt_ovf_q;
        rpm_sat_d   = rpm_sat_q;
        quad_err_d  = quad_err_q;
        stall_d     = stall_q;
        stall_cnt_d = stall_cnt_q;
        if (fire) begin
            valid_d = 1'b1;
            if (|res[PROD_W-1:RPM_W]) begin
                rpm_d     = '1;
                rpm_sat_d = 1'b1;
            end else begin
                rpm_d     = res[RPM_W-1:0];
                rpm_sat_d = 1'b0;
            end
            dir_d      = (MODE != 0) && snap_q[CNT_W-1];
            cnt_ovf_d  = snap_ovf_q;
            quad_err_d = snap_err_q;
            if (snap_q == '0)
                stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + STALL_ONE;
            else
                stall_cnt_d = '0;
            stall_d = (stall_cnt_d == STALL_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            hist_q      <= '0;
            gate_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            snap_q      <= '0;
            snap_vld_q  <= 1'b0;
            snap_ovf_q  <= 1'b0;
            snap_err_q  <= 1'b0;
            rpm_q       <= '0;
            dir_q       <= 1'b0;
            valid_q     <= 1'b0;
            cnt_ovf_q   <= 1'b0;
            rpm_sat_q   <= 1'b0;
            quad_err_q  <= 1'b0;
            stall_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            gate_q      <= gate_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            snap_q      <= snap_d;
            snap_vld_q  <= snap_vld_d;
            snap_ovf_q  <= snap_ovf_d;
            snap_err_q  <= snap_err_d;
            rpm_q       <= rpm_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            cnt_ovf_q   <= cnt_ovf_d;
            rpm_sat_q   <= rpm_sat_d;
            quad_err_q  <= quad_err_d;
            stall_q     <= stall_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.rpm       = rpm_q;
    assign bus.dir       = dir_q;
    assign bus.rpm_valid = valid_q;
    assign bus.cnt_ovf   = cnt_ovf_q;
    assign bus.rpm_sat   = rpm_sat_q;
    assign bus.quad_err  = quad_err_q;
    assign bus.stall     = stall_q;
endmodule

// File: tb/tb_enc_speed_meter.sv
// Directed bench: a MODE 0 meter (RPM_W=4) plus two MODE 1 meters (CNT_W=16 and CNT_W=5) sharing quadrature pins.
// All windows are 200 cycles; expected values are hand-computed as count*60>>8.
module tb_enc_speed_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic en0 = 1'b0, ta0 = 1'b0;
    logic en1 = 1'b0, ta1 = 1'b0, tb1 = 1'b0;

    enc_speed_meter_if #(.RPM_W(4))  if0 ();
    enc_speed_meter_if #(.RPM_W(10)) if1 ();
    enc_speed_meter_if #(.RPM_W(10)) if2 ();

    assign if0.en = en0;
    assign if0.tick_a = ta0;
    assign if0.tick_b = 1'b0;
    assign if1.en = en1;
    assign if1.tick_a = ta1;
    assign if1.tick_b = tb1;
    assign if2.en = en1;
    assign if2.tick_a = ta1;
    assign if2.tick_b = tb1;

    enc_speed_meter #(.MODE(0), .GATE_CYCLES(200), .CNT_W(16), .RPM_NUM(60), .RPM_SHIFT(8),
                      .RPM_W(4), .STALL_WINDOWS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    enc_speed_meter #(.MODE(1), .GATE_CYCLES(200), .CNT_W(16), .RPM_NUM(60), .RPM_SHIFT(8),
                      .RPM_W(10), .STALL_WINDOWS(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    enc_speed_meter #(.MODE(1), .GATE_CYCLES(200), .CNT_W(5), .RPM_NUM(60), .RPM_SHIFT(8),
                      .RPM_W(10), .STALL_WINDOWS(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int q_idx = 0;

    task automatic wait_valid(input int which, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 450) begin
            @(negedge clk);
            cyc++;
            hit = (which == 0) ? if0.rpm_valid : if1.rpm_valid;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL wait_valid dut%0d: no rpm_valid after %0d cycles, want one within 450", which, cyc);
            cyc = -1;
        end
    endtask

    task automatic pulses0(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            ta0 = 1'b1;
            repeat (hi) @(negedge clk);
            ta0 = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic qstep(input bit fwd);
        q_idx = fwd ? (q_idx + 1) % 4 : (q_idx + 3) % 4;
        {ta1, tb1} = gray[q_idx];
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        en0 = 1'b1;
        en1 = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({if0.rpm, if0.dir, if0.rpm_valid, if0.cnt_ovf, if0.rpm_sat, if0.quad_err, if0.stall} !== 10'd0) begin
            n_err++;
            $display("FAIL reset dut0: outputs=%h want 0", {if0.rpm, if0.dir, if0.rpm_valid, if0.cnt_ovf, if0.rpm_sat, if0.quad_err, if0.stall});
        end
        n_vec++;
        if ({if1.rpm, if1.dir, if1.rpm_valid, if1.cnt_ovf, if1.rpm_sat, if1.quad_err, if1.stall} !== 16'd0) begin
            n_err++;
            $display("FAIL reset dut1: outputs=%h want 0", {if1.rpm, if1.dir, if1.rpm_valid, if1.cnt_ovf, if1.rpm_sat, if1.quad_err, if1.stall});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stall;
        int cyc;
        for (int w = 1; w <= 4; w++) begin
            wait_valid(0, cyc);
            if (w == 1) begin
                n_vec++;
                if (cyc !== 201) begin n_err++; $display("FAIL first_valid: got %0d cycles want 201", cyc); end
            end
            if (w == 2) begin
                n_vec++;
                if (cyc !== 200) begin n_err++; $display("FAIL strobe_period: got %0d cycles want 200", cyc); end
            end
            if (w == 3) begin
                n_vec++;
                if (if0.stall !== 1'b0) begin n_err++; $display("FAIL stall_w3: got %b want 0", if0.stall); end
            end
            if (w == 4) begin
                n_vec++;
                if ({if0.stall, if0.rpm} !== {1'b1, 4'd0}) begin
                    n_err++; $display("FAIL stall_w4: got stall=%b rpm=%0d want stall=1 rpm=0", if0.stall, if0.rpm);
                end
            end
        end
    endtask

    task automatic test_boundary;
        int cyc;
        repeat (196) @(negedge clk);
        ta0 = 1'b1;
        wait_valid(0, cyc);
        n_vec++;
        if ({if0.stall, if0.rpm, if0.cnt_ovf} !== {1'b0, 4'd0, 1'b0} || cyc !== 4) begin
            n_err++;
            $display("FAIL last_cycle_edge: got stall=%b rpm=%0d ovf=%b after %0d cycles want stall=0 rpm=0 ovf=0 after 4",
                     if0.stall, if0.rpm, if0.cnt_ovf, cyc);
        end
        ta0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_channel;
        int cyc;
        wait_valid(0, cyc);
        pulses0(64, 1, 2);
        wait_valid(0, cyc);
        n_vec++;
        if ({if0.rpm, if0.rpm_sat, if0.cnt_ovf, if0.dir} !== {4'd15, 3'b000}) begin
            n_err++;
            $display("FAIL count64: got rpm=%0d sat=%b ovf=%b dir=%b want rpm=15 sat=0 ovf=0 dir=0",
                     if0.rpm, if0.rpm_sat, if0.cnt_ovf, if0.dir);
        end
        pulses0(70, 1, 1);
        wait_valid(0, cyc);
        n_vec++;
        if ({if0.rpm, if0.rpm_sat} !== {4'd15, 1'b1}) begin
            n_err++; $display("FAIL sat70: got rpm=%0d sat=%b want rpm=15 sat=1", if0.rpm, if0.rpm_sat);
        end
        pulses0(10, 1, 1);
        wait_valid(0, cyc);
        n_vec++;
        if ({if0.rpm, if0.rpm_sat} !== {4'd2, 1'b0}) begin
            n_err++; $display("FAIL count10: got rpm=%0d sat=%b want rpm=2 sat=0", if0.rpm, if0.rpm_sat);
        end
    endtask

    task automatic test_enable;
        int cyc;
        int bad;
        bad = 0;
        repeat (170) @(negedge clk);
        en0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ta0 = ~ta0;
            if (if0.rpm_valid !== 1'b0 || if0.rpm !== 4'd2) bad++;
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL en_low_hold: got %0d bad cycles want 0", bad); end
        ta0 = 1'b1;
        repeat (5) @(negedge clk);
        en0 = 1'b1;
        wait_valid(0, cyc);
        n_vec++;
        if (cyc !== 201 || if0.rpm !== 4'd0) begin
            n_err++; $display("FAIL en_restart: got %0d cycles rpm=%0d want 201 cycles rpm=0", cyc, if0.rpm);
        end
    endtask

    task automatic test_quadrature;
        int cyc;
        wait_valid(1, cyc);
        for (int i = 0; i < 40; i++) qstep(1'b1);
        wait_valid(1, cyc);
        n_vec++;
        if ({if1.rpm, if1.dir, if1.quad_err, if1.cnt_ovf} !== {10'd9, 3'b000}) begin
            n_err++; $display("FAIL quad_fwd dut1: got rpm=%0d dir=%b qerr=%b ovf=%b want 9 0 0 0", if1.rpm, if1.dir, if1.quad_err, if1.cnt_ovf);
        end
        n_vec++;
        if ({if2.rpm, if2.dir, if2.cnt_ovf} !== {10'd3, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL quad_fwd_sat dut2: got rpm=%0d dir=%b ovf=%b want 3 0 1", if2.rpm, if2.dir, if2.cnt_ovf);
        end
        for (int i = 0; i < 40; i++) qstep(1'b0);
        wait_valid(1, cyc);
        n_vec++;
        if ({if1.rpm, if1.dir} !== {10'd9, 1'b1}) begin
            n_err++; $display("FAIL quad_rev dut1: got rpm=%0d dir=%b want 9 1", if1.rpm, if1.dir);
        end
        n_vec++;
        if ({if2.rpm, if2.dir, if2.cnt_ovf} !== {10'd3, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL quad_rev_sat dut2: got rpm=%0d dir=%b ovf=%b want 3 1 1", if2.rpm, if2.dir, if2.cnt_ovf);
        end
        for (int i = 0; i < 40; i++) qstep(1'b1);
        for (int i = 0; i < 40; i++) qstep(1'b0);
        wait_valid(1, cyc);
        n_vec++;
        if ({if1.rpm, if1.dir, if1.cnt_ovf} !== {10'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL quad_net0 dut1: got rpm=%0d dir=%b ovf=%b want 0 0 0", if1.rpm, if1.dir, if1.cnt_ovf);
        end
        n_vec++;
        if ({if2.rpm, if2.dir, if2.cnt_ovf} !== {10'd3, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL quad_net_sat dut2: got rpm=%0d dir=%b ovf=%b want 3 1 1", if2.rpm, if2.dir, if2.cnt_ovf);
        end
    endtask

    task automatic test_illegal;
        int cyc;
        for (int i = 0; i < 10; i++) qstep(1'b1);
        q_idx = (q_idx + 2) % 4;
        {ta1, tb1} = gray[q_idx];
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) qstep(1'b1);
        wait_valid(1, cyc);
        n_vec++;
        if ({if1.rpm, if1.dir, if1.quad_err, if1.cnt_ovf} !== {10'd4, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL quad_err dut1: got rpm=%0d dir=%b qerr=%b ovf=%b want 4 0 1 0", if1.rpm, if1.dir, if1.quad_err, if1.cnt_ovf);
        end
        n_vec++;
        if ({if2.rpm, if2.quad_err, if2.cnt_ovf} !== {10'd3, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL quad_err dut2: got rpm=%0d qerr=%b ovf=%b want 3 1 1", if2.rpm, if2.quad_err, if2.cnt_ovf);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if1.rpm, if1.dir, if1.rpm_valid, if1.cnt_ovf, if1.rpm_sat, if1.quad_err, if1.stall,
             if2.rpm, if2.dir, if2.rpm_valid, if2.cnt_ovf, if2.rpm_sat, if2.quad_err, if2.stall} !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: dut1 rpm=%0d qerr=%b dut2 rpm=%0d qerr=%b ovf=%b want all outputs 0",
                     if1.rpm, if1.quad_err, if2.rpm, if2.quad_err, if2.cnt_ovf);
        end
        ta0 = 1'b0;
        ta1 = 1'b0;
        tb1 = 1'b0;
        q_idx = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(1, cyc);
        n_vec++;
        if (cyc !== 201) begin n_err++; $display("FAIL reset_release_valid: got %0d cycles want 201", cyc); end
        n_vec++;
        if ({if1.rpm, if1.quad_err, if1.stall, if2.rpm, if2.quad_err, if2.cnt_ovf} !== 25'd0) begin
            n_err++;
            $display("FAIL post_reset_window: dut1 rpm=%0d qerr=%b stall=%b dut2 rpm=%0d qerr=%b ovf=%b want all 0",
                     if1.rpm, if1.quad_err, if1.stall, if2.rpm, if2.quad_err, if2.cnt_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_boundary();
        test_single_channel();
        test_enable();
        test_quadrature();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/enc_speed_meter.md
# enc_speed_meter

Parametrised gated-window speed meter for BLDC encoder or Hall tick inputs, and the successor to the single-channel fixed-window RPM counter. It synchronises raw tick inputs into `clk` and counts edges over a programmable gate window, either rising edges on one channel or x4 quadrature steps with direction. It then scales the count to RPM with a multiply/shift, so no divider is needed. It sits between the encoder pins and the speed/commutation control loop, and publishes one `rpm_valid` strobe per window plus overflow, saturation, quadrature-error and stall status.

## Interface
- `MODE`, 0: 0 = single-channel rising-edge count on `tick_a`; 1 = x4 quadrature on `tick_a`/`tick_b`.
- `GATE_CYCLES`, 160000: window length in `clk` cycles, ≥ 4.
- `CNT_W`, 16: edge-counter width. The counter is signed in MODE 1.
- `RPM_NUM`, 60: scale multiplier, range 1..65535.
- `RPM_SHIFT`, 8: scale right-shift, range 0..31.
- `RPM_W`, 10: width of the `rpm` output.
- `STALL_WINDOWS`, 4: number of consecutive zero-count windows before `stall` asserts, ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: measurement enable.
- `tick_a` in 1: raw tick / encoder channel A, asynchronous to `clk`.
- `tick_b` in 1: encoder channel B, asynchronous to `clk`. Ignored when MODE=0.
- `rpm` out RPM_W: scaled speed magnitude, registered.
- `dir` out 1: 0 = forward/net non-negative, 1 = reverse. Always 0 when MODE=0.
- `rpm_valid` out 1: one-cycle strobe indicating that `rpm`, `dir` and the flags were updated.
- `cnt_ovf` out 1: the edge counter saturated during the reported window.
- `rpm_sat` out 1: the scaled result was clamped to the `rpm` range.
- `quad_err` out 1: the reported window contained at least one illegal quadrature transition.
- `stall` out 1: level signal indicating no motion.

## Operation
- **Input synchroniser:** each tick input passes through a 2-flop synchroniser followed by a history flop. Edge detection compares the synchronised value with the history flop.
- **MODE 0:** each synchronised rising edge of A increments the count. The count saturates at 2^CNT_W−1 and sets the window's ovf flag.
- **MODE 1:** decoding uses the previous and current synchronised AB pair.
  - Gray sequence 00→01→11→10→00 gives +1 per step; the reverse sequence gives −1.
  - If both channels change in the same cycle, the count is unchanged and the window's err flag is set.
  - The count saturates at ±(2^(CNT_W−1)−1) and sets the ovf flag.
- **Gate counter:** runs 0..GATE_CYCLES−1 and then wraps to 0.
  - In the cycle where the gate counter equals GATE_CYCLES−1 (the last window cycle), the snapshot captures the count including that cycle's edge.
  - On the same edge, the count, ovf and err flags clear and the next window starts.
- **Scale stage (cycle after snapshot):**
  - mag = |snap| in MODE 1, snap in MODE 0.
  - Compute prod = mag × RPM_NUM at full width (CNT_W+16 bits).
  - Compute res = prod >> RPM_SHIFT, truncating.
  - If res > 2^RPM_W−1, then `rpm` = all ones and `rpm_sat` = 1; otherwise `rpm` = res and `rpm_sat` = 0.
  - `dir` = sign of snap.
  - `cnt_ovf` and `quad_err` take the snapshot's flags.
  - `rpm_valid` = 1 for that cycle only.
- **Stall counter:** increments on each window whose snap = 0, saturating at STALL_WINDOWS. Any non-zero window clears it.
  - `stall` = (stall counter == STALL_WINDOWS).
  - `stall` updates together with `rpm_valid`.
- **`en` = 0:**
  - The gate counter, count, flags and scale pipeline are held at 0, and no `rpm_valid` is issued.
  - `rpm`, `dir`, `stall` and the status flags hold their last values.
  - The synchronisers keep running.
  - On `en` rising, the first window starts at gate count 0, and the first edge is not counted if it is a stale history edge (the history flop always tracks).
- **Reset:** asserting `rst_n` low at any point clears everything immediately, including any in-flight snapshot. The next window starts cleanly after release.

## Timing
- Reset values: `rpm`=0, `dir`=0, `rpm_valid`=0, `cnt_ovf`=0, `rpm_sat`=0, `quad_err`=0, `stall`=0. All synchroniser, history, gate, count and stall registers are 0.
- Pin-to-count latency: 3 `clk` edges (2 synchroniser + 1 edge detect).
- `rpm_valid` rises on the 1st `clk` edge after the edge that closes the window. The strobe period is exactly GATE_CYCLES.
- There is no window dead time: an edge in the last window cycle counts in that window, and an edge in the first cycle of the next window counts in the next window.
- Maximum countable rate: one edge per 2 `clk` cycles per channel. Faster input is undefined, and in MODE 1 it is flagged via `quad_err`.

## Test plan
- **Single-channel count:** MODE=0, GATE_CYCLES=200, `en`=1, 64 rising edges at 3-cycle period inside one window -> `rpm_valid` pulse, `rpm`=15 (3840>>8), `rpm_sat`=0, `cnt_ovf`=0, `dir`=0.
- **Saturation:** as above with RPM_W=4 and 70 edges -> `rpm`=15, `rpm_sat`=1. The next window with 10 edges -> `rpm`=2, `rpm_sat`=0.
- **Quadrature direction:** MODE=1, 40 forward Gray steps -> `rpm`=9, `dir`=0. Next window, 40 reverse steps -> `rpm`=9, `dir`=1. A window with 40 forward and 40 reverse steps -> `rpm`=0.
- **Illegal transition:** MODE=1, A and B toggle in the same cycle once among 20 forward steps -> `quad_err`=1, `rpm`=4 (20 counted).
- **Stall and boundary:** STALL_WINDOWS=4, no edges -> `stall`=1 exactly at the 4th `rpm_valid`. A single edge landing in the last window cycle -> reported in that window, `stall` clears.
- **Reset/enable mid-window:** `rst_n` low mid-window -> all outputs 0 immediately, and the first `rpm_valid` arrives GATE_CYCLES+1 cycles after release. `en` low for 50 cycles -> no strobe and outputs hold.
